// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: state codes, default widths and the iteration bound.
package mult_div_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 6;
    localparam int ITER_LAST  = DATA_W_DEF - 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MULT_RUN = 3'd1;
    localparam logic [2:0] ST_DIV_RUN  = 3'd2;
    localparam logic [2:0] ST_DIV_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_DZERO    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_MULT_RUN = ST_MULT_RUN,
        S_DIV_RUN  = ST_DIV_RUN,
        S_DIV_FIX  = ST_DIV_FIX,
        S_DONE     = ST_DONE,
        S_DZERO    = ST_DZERO
    } state_t;

    // Counter value on the final iteration for a given operand width.
    function automatic int iter_last(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the control unit (master) and the sequencer (slave).
interface mult_div_seq_if
    import mult_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              start_mult;
    logic              start_div;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic              zero_div;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, zero_div, hi, lo
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, zero_div, hi, lo
    );
endinterface

// File: rtl/mult_div_seq_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The remainder entering each step is always below the divisor.
module div_step
    import mult_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_dvs,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_qbit
);
    // One extra bit: the shifted remainder can reach 2*|b|-1 when |b| has its MSB set.
    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_dvs;

    assign w_shift = {i_rem, i_bit};
    assign w_dvs   = {1'b0, i_dvs};
    assign o_qbit  = (w_shift >= w_dvs);
    assign o_rem   = o_qbit ? DATA_W'(w_shift - w_dvs) : DATA_W'(w_shift);
endmodule

// File: rtl/mult_div_seq.sv
// Multi-cycle Booth multiply / restoring divide sequencer loading HI/LO.
// Control holds in its wait state while busy is high.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_seq_if.slave         bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(iter_last(DATA_W));

    state_t                   r_state, w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W:0]   r_acc;
    logic signed [DATA_W:0]   r_m;
    logic [DATA_W-1:0]        r_q;
    logic                     r_q1;
    logic [DATA_W-1:0]        r_rem;
    logic [DATA_W-1:0]        r_dvs;
    logic                     r_neg_q;
    logic                     r_neg_r;
    logic [DATA_W-1:0]        r_hi;
    logic [DATA_W-1:0]        r_lo;

    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W:0]   w_acc_next;
    logic [DATA_W-1:0]        w_q_next;
    logic [DATA_W-1:0]        w_a_mag;
    logic [DATA_W-1:0]        w_b_mag;
    logic [DATA_W-1:0]        w_rem_next;
    logic                     w_qbit;
    logic                     w_b_zero;

    assign w_a_mag  = bus.a[DATA_W-1] ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag  = bus.b[DATA_W-1] ? (~bus.b + 1'b1) : bus.b;
    assign w_b_zero = (bus.b == '0);

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[DATA_W-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    // Booth step: add/subtract M per {Q0,Q-1}, then arithmetic shift of {ACC,Q,Q-1}.
    always_comb begin
        w_sum = r_acc;
        unique case ({r_q[0], r_q1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
        w_acc_next = w_sum >>> 1;
        w_q_next   = {w_sum[0], r_q[DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.zero_div = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start_mult)     w_state_next = S_MULT_RUN;
                else if (bus.start_div) w_state_next = w_b_zero ? S_DZERO : S_DIV_RUN;
            end
            S_MULT_RUN: if (r_cnt == LAST) w_state_next = S_DONE;
            S_DIV_RUN:  if (r_cnt == LAST) w_state_next = S_DIV_FIX;
            S_DIV_FIX:  w_state_next = S_DONE;
            S_DONE: begin
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            S_DZERO: begin
                bus.zero_div = 1'b1;
                w_state_next = S_IDLE;
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.start_mult) begin
                        r_m   <= {bus.a[DATA_W-1], bus.a};
                        r_acc <= '0;
                        r_q   <= bus.b;
                        r_q1  <= 1'b0;
                    end else if (bus.start_div && !w_b_zero) begin
                        r_rem   <= '0;
                        r_q     <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
                        r_neg_r <= bus.a[DATA_W-1];
                    end
                end
                S_MULT_RUN: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_next;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_hi <= w_acc_next[DATA_W-1:0];
                        r_lo <= w_q_next;
                    end
                end
                S_DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[DATA_W-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV_FIX: begin
                    r_lo <= r_neg_q ? (~r_q + 1'b1) : r_q;
                    r_hi <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi = r_hi;
    assign bus.lo = r_lo;
endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq with hand-computed expected HI/LO, latency and pulses.
module tb_mult_div_seq;
    import mult_div_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat_o;
    logic [1:0] evt_o;
    logic busy_o;
    int   n_done;

    mult_div_seq_if #(.DATA_W(32)) bus ();

    mult_div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start edge E0 is the posedge after the start is raised; lat counts cycles after E0.
    task automatic run_op(input logic is_div, input logic [31:0] av, input logic [31:0] bv,
                          input int inj_at);
        @(negedge clk);
        bus.a = av; bus.b = bv;
        bus.start_mult = !is_div; bus.start_div = is_div;
        @(negedge clk);
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        evt_o  = 2'b00;
        busy_o = 1'b1;
        for (lat_o = 0; lat_o < 60; lat_o++) begin
            if (!bus.busy) busy_o = 1'b0;
            if (bus.done || bus.zero_div) begin
                evt_o = {bus.zero_div, bus.done};
                break;
            end
            bus.start_div = (lat_o == inj_at);
            @(negedge clk);
        end
        bus.start_div = 1'b0;
    endtask

    task automatic expect_op(input string tag, input int lat_exp, input logic [1:0] evt_exp,
                             input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        check_eq({tag, ".latency"}, 64'(lat_o), 64'(lat_exp));
        check_eq({tag, ".pulse"}, 64'(evt_o), 64'(evt_exp));
        check_eq({tag, ".busy"}, 64'(busy_o), 64'd1);
        check_eq({tag, ".hi"}, 64'(bus.hi), 64'(hi_exp));
        check_eq({tag, ".lo"}, 64'(bus.lo), 64'(lo_exp));
        @(negedge clk);
        check_eq({tag, ".after"}, {61'd0, bus.busy, bus.done, bus.zero_div}, 64'd0);
    endtask

    initial begin
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        bus.a = '0; bus.b = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset.ctrl", {61'd0, bus.busy, bus.done, bus.zero_div}, 64'd0);
        check_eq("reset.hi", 64'(bus.hi), 64'd0);
        check_eq("reset.lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        expect_op("mul_7xm3", ITER_LAST + 1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1);
        expect_op("mul_minxmin", 32, 2'b01, 32'h4000_0000, 32'h0000_0000);

        run_op(1'b0, 32'h1234_5678, 32'h10, -1);
        expect_op("mul_pos", 32, 2'b01, 32'h0000_0001, 32'h2345_6780);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        expect_op("div_m7by2", 33, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        expect_op("div_7bym2", 33, 2'b01, 32'h0000_0001, 32'hFFFF_FFFD);

        run_op(1'b1, 32'h0000_3412, 32'h100, -1);
        expect_op("div_preload", 33, 2'b01, 32'h12, 32'h34);

        run_op(1'b1, 32'd5, 32'd0, -1);
        expect_op("div_zero", 0, 2'b10, 32'h12, 32'h34);

        repeat (5) @(negedge clk);
        check_eq("hold.hi", 64'(bus.hi), 64'h12);
        check_eq("hold.lo", 64'(bus.lo), 64'h34);

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        expect_op("div_overflow", 33, 2'b01, 32'h0, 32'h8000_0000);

        run_op(1'b0, 32'd3, 32'd4, 10);
        expect_op("busy_ignore", 32, 2'b01, 32'h0, 32'd12);

        // Abandon a multiply mid-flight with reset.
        @(negedge clk);
        bus.a = 32'd3; bus.b = 32'd4; bus.start_mult = 1'b1;
        @(negedge clk);
        bus.start_mult = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("rst_mid.busy_before", 64'(bus.busy), 64'd1);
        check_eq("rst_mid.lo_before", 64'(bus.lo), 64'd12);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("rst_mid.busy", 64'(bus.busy), 64'd0);
        check_eq("rst_mid.hi", 64'(bus.hi), 64'd0);
        check_eq("rst_mid.lo", 64'(bus.lo), 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.zero_div || bus.busy) n_done++;
        end
        check_eq("rst_mid.no_done", 64'(n_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
